// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) for N lanes. AR fields and R valid/ready are
// per lane (packed slices); the R payload is shared by every lane.
interface axi_rd_arbiter_if #(
  parameter int N          = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
) ();
  logic [N-1:0]            ARVALID;
  logic [N-1:0]            ARREADY;
  logic [N*ID_WIDTH-1:0]   ARID;
  logic [N*ADDR_WIDTH-1:0] ARADDR;
  logic [N*LEN_WIDTH-1:0]  ARLEN;
  logic [N*3-1:0]          ARSIZE;
  logic [N*2-1:0]          ARBURST;
  logic [N-1:0]            RVALID;
  logic [N-1:0]            RREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;

  modport master (
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    input  ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );

  modport slave (
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
    output ARREADY, RVALID, RID, RDATA, RRESP, RLAST
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between NUM_M masters, one burst
// in flight at a time, with a sticky check of returned beats against ARLEN.
//
// state | meaning
// IDLE  | no burst; pick next requester after last_grant
// ADDR  | AR of granted master routed to slave, waiting for AR handshake
// DATA  | R beats routed to granted master until the RLAST handshake
module axi_rd_arbiter #(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                     axi_ACLK,
  input  logic                     axi_ARESETn,
  axi_rd_arbiter_if.slave          m_bus,
  axi_rd_arbiter_if.master         s_bus,
  output logic [$clog2(NUM_M)-1:0] grant_o,
  output logic                     busy_o,
  output logic                     len_err_o
);
  localparam int GW = $clog2(NUM_M);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state, state_d;
  logic [GW-1:0]        grant, grant_d, last_grant, last_grant_d;
  logic [LEN_WIDTH:0]   beat_cnt, beat_cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 len_err, len_err_d;
  logic [GW-1:0]        arb_idx;
  logic                 arb_found;
  logic                 r_hs;

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_M - 1);
      beat_cnt   <= '0;
      len_q      <= '0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      beat_cnt   <= beat_cnt_d;
      len_q      <= len_d;
      len_err    <= len_err_d;
    end
  end

  // Search starts just after the last served master, so a re-requester waits its turn.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_idx   = last_grant;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = (int'(last_grant) + i) % NUM_M;
      if (!arb_found && m_bus.ARVALID[idx]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state;
    grant_d       = grant;
    last_grant_d  = last_grant;
    beat_cnt_d    = beat_cnt;
    len_d         = len_q;
    len_err_d     = len_err;
    r_hs          = 1'b0;
    s_bus.ARVALID = '0;
    s_bus.ARID    = '0;
    s_bus.ARADDR  = '0;
    s_bus.ARLEN   = '0;
    s_bus.ARSIZE  = '0;
    s_bus.ARBURST = '0;
    s_bus.RREADY  = '0;
    m_bus.ARREADY = '0;
    m_bus.RVALID  = '0;
    m_bus.RID     = '0;
    m_bus.RDATA   = '0;
    m_bus.RRESP   = '0;
    m_bus.RLAST   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_bus.ARVALID[0]       = m_bus.ARVALID[grant];
        s_bus.ARID             = m_bus.ARID[grant*ID_WIDTH +: ID_WIDTH];
        s_bus.ARADDR           = m_bus.ARADDR[grant*ADDR_WIDTH +: ADDR_WIDTH];
        s_bus.ARLEN            = m_bus.ARLEN[grant*LEN_WIDTH +: LEN_WIDTH];
        s_bus.ARSIZE           = m_bus.ARSIZE[grant*3 +: 3];
        s_bus.ARBURST          = m_bus.ARBURST[grant*2 +: 2];
        m_bus.ARREADY[grant]   = s_bus.ARREADY[0];
        if (m_bus.ARVALID[grant] && s_bus.ARREADY[0]) begin
          len_d      = m_bus.ARLEN[grant*LEN_WIDTH +: LEN_WIDTH];
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        m_bus.RVALID[grant] = s_bus.RVALID[0];
        s_bus.RREADY[0]     = m_bus.RREADY[grant];
        m_bus.RID           = s_bus.RID;
        m_bus.RDATA         = s_bus.RDATA;
        m_bus.RRESP         = s_bus.RRESP;
        m_bus.RLAST         = s_bus.RLAST;
        r_hs                = s_bus.RVALID[0] && m_bus.RREADY[grant];
        if (r_hs) begin
          beat_cnt_d = beat_cnt + (LEN_WIDTH+1)'(1);
          if (s_bus.RLAST) begin
            last_grant_d = grant;
            state_d      = IDLE;
            if (beat_cnt != {1'b0, len_q}) len_err_d = 1'b1;
          end else if (beat_cnt == {1'b0, len_q}) begin
            // Slave overran ARLEN; keep routing beats until it finally sends RLAST.
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o   = grant;
  assign busy_o    = (state != IDLE);
  assign len_err_o = len_err;
endmodule
